// File: rtl/xfer_seq.sv
// Purpose: fill/scan sequencer for the two-memory datapath (fill A, copy passing A words into B).
// Latency: a run lasts 2*DEPTH+1 cycles from the start edge to the done pulse.
// Backpressure: none; start is ignored unless idle, and abort cancels a run on the next edge.
module xfer_seq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          cmp_ok,
  output logic          WEA,
  output logic          IncA,
  output logic          WEB,
  output logic          IncB,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [AW:0]   count_b,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE_A  = AW'(1);
  localparam logic [AW:0]   ONE_C  = (AW + 1)'(1);

  state_t state;
  state_t state_nxt;

  // State register; reset forces IDLE regardless of start/abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and enables: Moore except WEB/IncB, which follow cmp_ok during SCAN.
  always_comb begin
    state_nxt = state;
    WEA       = 1'b0;
    IncA      = 1'b0;
    WEB       = 1'b0;
    IncB      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        WEA  = 1'b1;
        IncA = 1'b1;
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (addr_a == LAST_A) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        IncA = 1'b1;
        WEB  = cmp_ok;
        IncB = cmp_ok;
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (addr_a == LAST_A) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Address counters and B write count. The A counter wraps to 0 on its own at DEPTH-1,
  // and B can take at most DEPTH writes per run, so neither B address nor count overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_a  <= '0;
      addr_b  <= '0;
      count_b <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_a  <= '0;
            addr_b  <= '0;
            count_b <= '0;
          end
        end
        FILL: begin
          if (abort) begin
            addr_a <= '0;
            addr_b <= '0;
          end else begin
            addr_a <= addr_a + ONE_A;
          end
        end
        SCAN: begin
          // A write issued in the abort cycle still lands in B, so it is counted.
          if (cmp_ok) begin
            count_b <= count_b + ONE_C;
          end
          if (abort) begin
            addr_a <= '0;
            addr_b <= '0;
          end else begin
            addr_a <= addr_a + ONE_A;
            if (cmp_ok) begin
              addr_b <= addr_b + ONE_A;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xfer_seq.sv
// Purpose: directed self-checking bench for xfer_seq with DEPTH=8.
// Latency: inputs change on the falling edge and outputs are sampled 1 ns later.
// Backpressure: not applicable; every wait is a fixed cycle count.
module tb_xfer_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       cmp_ok;
  logic       WEA;
  logic       IncA;
  logic       WEB;
  logic       IncB;
  logic [2:0] addr_a;
  logic [2:0] addr_b;
  logic [3:0] count_b;
  logic       busy;
  logic       done;

  int passed = 0;
  int total  = 0;

  xfer_seq #(.DEPTH(8), .AW(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .cmp_ok  (cmp_ok),
    .WEA     (WEA),
    .IncA    (IncA),
    .WEB     (WEB),
    .IncB    (IncB),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .count_b (count_b),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Flags packed as {WEA, IncA, WEB, IncB, busy, done}.
  function automatic logic [5:0] flags();
    return {WEA, IncA, WEB, IncB, busy, done};
  endfunction

  task automatic test_reset();
    logic [15:0] got;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cmp_ok = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      got = {flags(), addr_a, addr_b, count_b};
      total++;
      if (got !== 16'h0000)
        $display("FAIL reset_idle[%0d] got=%h expected=0000", i, got);
      else
        passed++;
      @(negedge clk);
    end
  endtask

  // Full run; mask bit k = cmp_ok value while SCAN visits A address k.
  // A start is also raised during DONE, which must be ignored.
  task automatic test_run(input logic [7:0] mask, input logic [3:0] exp_cnt, input string nm);
    logic [15:0] got;
    logic [15:0] exp;
    logic [5:0]  ef;
    logic [2:0]  ea;
    logic [2:0]  eb;
    logic [3:0]  ec;
    logic        pass_now;
    eb = 3'd0;
    ec = 4'd0;
    @(negedge clk);
    start = 1'b1; cmp_ok = 1'b0; abort = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0)
      $display("FAIL %s_start_idle busy=%b expected=0", nm, busy);
    else
      passed++;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      pass_now = 1'b0;
      if (c <= 8) begin
        ea = 3'(c - 1);
        ef = 6'b110010;
      end else if (c <= 16) begin
        ea = 3'(c - 9);
        pass_now = mask[ea];
        ef = {1'b0, 1'b1, pass_now, pass_now, 1'b1, 1'b0};
      end else begin
        ea = 3'd0;
        ef = 6'b000001;
      end
      cmp_ok = pass_now;
      start  = (c == 17);
      #1;
      got = {flags(), addr_a, addr_b, count_b};
      exp = {ef, ea, eb, ec};
      total++;
      if (got !== exp)
        $display("FAIL %s_cycle%0d got=%h expected=%h", nm, c, got, exp);
      else
        passed++;
      if (pass_now) begin
        eb = eb + 3'd1;
        ec = ec + 4'd1;
      end
      @(negedge clk);
    end
    start = 1'b0; cmp_ok = 1'b0;
    #1;
    got = {flags(), addr_a, addr_b, count_b};
    exp = {6'b000000, 3'd0, eb, ec};
    total++;
    if (got !== exp)
      $display("FAIL %s_after_done got=%h expected=%h", nm, got, exp);
    else
      passed++;
    total++;
    if (count_b !== exp_cnt)
      $display("FAIL %s_count_b got=%0d expected=%0d", nm, count_b, exp_cnt);
    else
      passed++;
  endtask

  task automatic test_abort();
    logic [15:0] got;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; cmp_ok = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      start  = (c == 3) || (c == 10);
      cmp_ok = (c == 9) || (c == 10);
      abort  = (c == 12);
      #1;
      if (c == 4) begin
        got = {flags(), addr_a, addr_b, count_b};
        total++;
        if (got !== {6'b110010, 3'd3, 3'd0, 4'd0})
          $display("FAIL abort_start_in_fill got=%h expected=%h", got, {6'b110010, 3'd3, 3'd0, 4'd0});
        else
          passed++;
      end
      if (c == 11) begin
        got = {flags(), addr_a, addr_b, count_b};
        total++;
        if (got !== {6'b010010, 3'd2, 3'd2, 4'd2})
          $display("FAIL abort_start_in_scan got=%h expected=%h", got, {6'b010010, 3'd2, 3'd2, 4'd2});
        else
          passed++;
      end
      if (c == 12) begin
        got = {flags(), addr_a, addr_b, count_b};
        total++;
        if (got !== {6'b010010, 3'd3, 3'd2, 4'd2})
          $display("FAIL abort_cycle got=%h expected=%h", got, {6'b010010, 3'd3, 3'd2, 4'd2});
        else
          passed++;
      end
      @(negedge clk);
    end
    abort = 1'b0; cmp_ok = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      got = {flags(), addr_a, addr_b, count_b};
      total++;
      if (got !== {6'b000000, 3'd0, 3'd0, 4'd2})
        $display("FAIL abort_idle[%0d] got=%h expected=%h", i, got, {6'b000000, 3'd0, 3'd0, 4'd2});
      else
        passed++;
      @(negedge clk);
    end
    // start and abort together in IDLE: start wins and clears the count.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b1;
    #1;
    got = {flags(), addr_a, addr_b, count_b};
    total++;
    if (got !== {6'b110010, 3'd0, 3'd0, 4'd0})
      $display("FAIL start_beats_abort got=%h expected=%h", got, {6'b110010, 3'd0, 3'd0, 4'd0});
    else
      passed++;
    @(negedge clk);
    abort = 1'b0;
    #1;
    got = {flags(), addr_a, addr_b, count_b};
    total++;
    if (got !== 16'h0000)
      $display("FAIL abort_in_fill got=%h expected=0000", got);
    else
      passed++;
  endtask

  // Expects to start idle with count_b == 3 from the previous run.
  task automatic test_reset_midrun();
    logic [15:0] got;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    got = {flags(), addr_a, addr_b, count_b};
    total++;
    if (got !== 16'h0000)
      $display("FAIL reset_clears_count got=%h expected=0000", got);
    else
      passed++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) begin
        rst = 1'b1; start = 1'b1; abort = 1'b1;
      end
      #1;
      if (c == 6) begin
        got = {flags(), addr_a, addr_b, count_b};
        total++;
        if (got !== {6'b110010, 3'd5, 3'd0, 4'd0})
          $display("FAIL reset_midrun_pre got=%h expected=%h", got, {6'b110010, 3'd5, 3'd0, 4'd0});
        else
          passed++;
      end
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    #1;
    got = {flags(), addr_a, addr_b, count_b};
    total++;
    if (got !== 16'h0000)
      $display("FAIL reset_midrun_post got=%h expected=0000", got);
    else
      passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run(8'b0000_0000, 4'd0, "nopass");
    test_run(8'b1111_1111, 4'd8, "allpass");
    test_abort();
    test_run(8'b0101_0010, 4'd3, "sparse");
    test_reset_midrun();
    test_run(8'b1000_0001, 4'd2, "fresh");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
